// File: rtl/ssd1309_spi_monitor.sv
// ssd1309_spi_monitor: oversampling SSD1309 4-wire SPI receiver with command decode and pixel addressing
module ssd1309_spi_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int COL_MAX     = 127,
    parameter int PAGE_MAX    = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_i,
    input  logic       sdin_i,
    input  logic       dc_i,
    input  logic       cs_i,
    input  logic       res_i,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       pix_we,
    output logic [6:0] pix_col,
    output logic [2:0] pix_page,
    output logic [1:0] addr_mode,
    output logic       display_on,
    output logic       frame_err
);
    typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_q, sdin_q, dc_q, cs_q, res_q;
    logic sclk_s, sdin_s, dc_s, cs_s, res_s, sclk_prev_q, rise_q, cs_err;
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic byte_valid_q, byte_dc_q, pix_we_q;
    logic [7:0] byte_data_q, cmd_q, cmd_d;
    logic [6:0] pix_col_q, col_q, col_d, col_lo_q, col_lo_d, col_hi_q, col_hi_d, arg_q, arg_d;
    logic [2:0] pix_page_q, page_q, page_d, pg_lo_q, pg_lo_d, pg_hi_q, pg_hi_d;
    logic [1:0] mode_q, mode_d;
    logic disp_q, disp_d, frame_err_q, frame_err_d, cmd_v, dat_v, col_wrap, pg_wrap;
    logic [7:0] b;

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign sdin_s = sdin_q[SYNC_STAGES-1];
    assign dc_s   = dc_q[SYNC_STAGES-1];
    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign res_s  = res_q[SYNC_STAGES-1];
    assign b      = byte_data_q;
    assign cmd_v  = byte_valid_q & ~byte_dc_q;
    assign dat_v  = byte_valid_q & byte_dc_q;
    assign cs_err = res_s & cs_s & (bit_cnt_q != 3'd0);
    assign col_wrap = col_q == col_hi_q;
    assign pg_wrap  = page_q == pg_hi_q;

    // Pin synchronizers plus a registered sclk rising-edge strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q <= '0;
            sdin_q <= '0;
            dc_q <= '0;
            cs_q <= '1;
            res_q <= '1;
            sclk_prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            sdin_q <= {sdin_q[SYNC_STAGES-2:0], sdin_i};
            dc_q <= {dc_q[SYNC_STAGES-2:0], dc_i};
            cs_q <= {cs_q[SYNC_STAGES-2:0], cs_i};
            res_q <= {res_q[SYNC_STAGES-2:0], res_i};
            sclk_prev_q <= sclk_s;
            rise_q <= sclk_s & ~sclk_prev_q;
        end
    end

    // Byte assembly; a completed data byte captures the pre-advance pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt_q <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q <= '0;
            byte_dc_q <= 1'b0;
            pix_we_q <= 1'b0;
            pix_col_q <= '0;
            pix_page_q <= '0;
        end else begin
            byte_valid_q <= 1'b0;
            pix_we_q <= 1'b0;
            if (!res_s || cs_s) begin
                bit_cnt_q <= '0;
            end else if (rise_q) begin
                shift_q <= {shift_q[5:0], sdin_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_valid_q <= 1'b1;
                    byte_data_q <= {shift_q, sdin_s};
                    byte_dc_q <= dc_s;
                    pix_we_q <= dc_s;
                    if (dc_s) begin
                        pix_col_q <= col_q;
                        pix_page_q <= page_q;
                    end
                end
            end
        end
    end

    // Parser state register
    always_ff @(posedge clk) begin
        if (!rst_n || !res_s) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Parser next state: a data byte always aborts a pending command
    always_comb begin
        state_d = state_q;
        if (dat_v) state_d = IDLE;
        else if (cmd_v)
            case (state_q)
                IDLE: state_d = (b inside {8'h20, 8'h21, 8'h22, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                                           8'hD5, 8'hD9, 8'hDA, 8'hDB}) ? ARG1 : IDLE;
                ARG1: state_d = (cmd_q == 8'h21 || cmd_q == 8'h22) ? ARG2 : IDLE;
                default: state_d = IDLE;
            endcase
    end

    // Parser outputs: command effects and pointer advance after data bytes
    always_comb begin
        cmd_d = cmd_q;
        arg_d = arg_q;
        mode_d = mode_q;
        disp_d = disp_q;
        col_d = col_q;
        page_d = page_q;
        col_lo_d = col_lo_q;
        col_hi_d = col_hi_q;
        pg_lo_d = pg_lo_q;
        pg_hi_d = pg_hi_q;
        if (cmd_v && state_q == IDLE) begin
            cmd_d = b;
            if (b[7:4] == 4'h0) col_d[3:0] = b[3:0];
            if (b[7:3] == 5'b00010) col_d[6:4] = b[2:0];
            if (b[7:3] == 5'b10110) page_d = b[2:0];
            if (b[7:1] == 7'b1010111) disp_d = b[0];
        end
        if (cmd_v && state_q == ARG1) begin
            arg_d = b[6:0];
            if (cmd_q == 8'h20) mode_d = (b[1:0] == 2'd3) ? 2'd2 : b[1:0];
        end
        if (cmd_v && state_q == ARG2 && cmd_q == 8'h21) begin
            col_lo_d = arg_q;
            col_hi_d = b[6:0];
            col_d = arg_q;
        end
        if (cmd_v && state_q == ARG2 && cmd_q == 8'h22) begin
            pg_lo_d = arg_q[2:0];
            pg_hi_d = b[2:0];
            page_d = arg_q[2:0];
        end
        if (dat_v)
            case (mode_q)
                2'd0: begin
                    col_d = col_wrap ? col_lo_q : col_q + 7'd1;
                    page_d = col_wrap ? (pg_wrap ? pg_lo_q : page_q + 3'd1) : page_q;
                end
                2'd1: begin
                    page_d = pg_wrap ? pg_lo_q : page_q + 3'd1;
                    col_d = pg_wrap ? (col_wrap ? col_lo_q : col_q + 7'd1) : col_q;
                end
                default: col_d = (col_q == 7'(COL_MAX)) ? 7'd0 : col_q + 7'd1;
            endcase
        frame_err_d = frame_err_q | cs_err | (dat_v & (state_q != IDLE));
    end

    // Parser datapath registers; OLED reset restores defaults but keeps frame_err
    always_ff @(posedge clk) begin
        if (!rst_n || !res_s) begin
            cmd_q <= '0;
            arg_q <= '0;
            mode_q <= 2'd2;
            disp_q <= 1'b0;
            col_q <= '0;
            page_q <= '0;
            col_lo_q <= '0;
            col_hi_q <= 7'(COL_MAX);
            pg_lo_q <= '0;
            pg_hi_q <= 3'(PAGE_MAX);
        end else begin
            cmd_q <= cmd_d;
            arg_q <= arg_d;
            mode_q <= mode_d;
            disp_q <= disp_d;
            col_q <= col_d;
            page_q <= page_d;
            col_lo_q <= col_lo_d;
            col_hi_q <= col_hi_d;
            pg_lo_q <= pg_lo_d;
            pg_hi_q <= pg_hi_d;
        end
    end

    // Sticky protocol-error flag
    always_ff @(posedge clk) begin
        if (!rst_n) frame_err_q <= 1'b0;
        else frame_err_q <= frame_err_d;
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign byte_dc    = byte_dc_q;
    assign pix_we     = pix_we_q;
    assign pix_col    = pix_col_q;
    assign pix_page   = pix_page_q;
    assign addr_mode  = mode_q;
    assign display_on = disp_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_ssd1309_spi_monitor.sv
// tb_ssd1309_spi_monitor: directed SPI stimulus with a queue scoreboard checking every received byte
module tb_ssd1309_spi_monitor;
    logic clk = 0, rst_n = 0, sclk_i = 0, sdin_i = 0, dc_i = 0, cs_i = 1, res_i = 1;
    logic byte_valid, byte_dc, pix_we, display_on, frame_err;
    logic [7:0] byte_data;
    logic [6:0] pix_col;
    logic [2:0] pix_page;
    logic [1:0] addr_mode;

    ssd1309_spi_monitor dut (
        .clk(clk), .rst_n(rst_n), .sclk_i(sclk_i), .sdin_i(sdin_i), .dc_i(dc_i),
        .cs_i(cs_i), .res_i(res_i), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_dc(byte_dc), .pix_we(pix_we), .pix_col(pix_col), .pix_page(pix_page),
        .addr_mode(addr_mode), .display_on(display_on), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       dc;
        logic [6:0] col;
        logic [2:0] pg;
        int         at;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int n_chk = 0, n_fail = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // The 8th sclk rise is driven right after a negedge at cycle N; byte_valid is due at N+4
    task automatic send_bits(input logic [7:0] b, input int nb, input logic dc,
                             input logic [6:0] col, input logic [2:0] pg);
        dc_i = dc;
        cs_i = 0;
        for (int i = 7; i > 7 - nb; i--) begin
            sdin_i = b[i];
            sclk_i = 0;
            tick(4);
            sclk_i = 1;
            if (i == 0) q.push_back('{b, dc, col, pg, cyc + 4});
            tick(4);
        end
        sclk_i = 0;
        tick(2);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_bits(b, 8, 1'b0, 7'd0, 3'd0);
    endtask

    task automatic dat(input logic [7:0] b, input logic [6:0] col, input logic [2:0] pg);
        send_bits(b, 8, 1'b1, col, pg);
    endtask

    // Monitor: pop one expectation per byte_valid
    always @(negedge clk) begin
        if (byte_valid || pix_we) chk("pix_we_eq_valid_and_dc", pix_we, byte_valid & byte_dc);
        if (byte_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_byte: got 0x%02h with nothing queued", byte_data);
            end else begin
                e = q.pop_front();
                chk("byte_data", byte_data, e.d);
                chk("byte_dc", byte_dc, e.dc);
                chk("byte_latency_cycle", cyc, e.at);
                if (e.dc) begin
                    chk("pix_col", pix_col, e.col);
                    chk("pix_page", pix_page, e.pg);
                end
            end
        end
    end

    initial begin
        tick(4);
        rst_n = 1;
        tick(1);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_data", byte_data, 0);
        chk("rst_byte_dc", byte_dc, 0);
        chk("rst_pix_we", pix_we, 0);
        chk("rst_pix_col", pix_col, 0);
        chk("rst_pix_page", pix_page, 0);
        chk("rst_addr_mode", addr_mode, 2);
        chk("rst_display_on", display_on, 0);
        chk("rst_frame_err", frame_err, 0);

        cmd(8'hA5);
        cmd(8'h3C);

        cmd(8'h20); cmd(8'h00);
        cmd(8'h21); cmd(8'h7E); cmd(8'h7F);
        cmd(8'h22); cmd(8'h06); cmd(8'h07);
        chk("horiz_mode", addr_mode, 0);
        dat(8'h11, 126, 6); dat(8'h22, 127, 6); dat(8'h33, 126, 7);
        dat(8'h44, 127, 7); dat(8'h55, 126, 6);

        cmd(8'h20); cmd(8'h01);
        cmd(8'h21); cmd(8'h00); cmd(8'h01);
        cmd(8'h22); cmd(8'h00); cmd(8'h01);
        chk("vert_mode", addr_mode, 1);
        dat(8'h66, 0, 0); dat(8'h77, 0, 1); dat(8'h88, 1, 0);
        dat(8'h99, 1, 1); dat(8'hAA, 0, 0);

        cmd(8'h20); cmd(8'h02);
        chk("page_mode", addr_mode, 2);
        cmd(8'hB3); cmd(8'h0F); cmd(8'h17);
        dat(8'hBB, 127, 3); dat(8'hCC, 0, 3);
        chk("no_err_before_partial", frame_err, 0);

        send_bits(8'hF0, 5, 1'b0, 7'd0, 3'd0);
        cs_i = 1;
        tick(8);
        chk("partial_frame_err", frame_err, 1);
        cmd(8'hAF);
        chk("display_on_after_af", display_on, 1);

        rst_n = 0;
        tick(2);
        rst_n = 1;
        tick(1);
        chk("rst2_frame_err", frame_err, 0);
        chk("rst2_display_on", display_on, 0);
        cmd(8'h21);
        dat(8'hFF, 0, 0);
        chk("abort_frame_err", frame_err, 1);
        cmd(8'hAF);
        chk("parser_idle_after_abort", display_on, 1);
        cmd(8'h20); cmd(8'h00);
        chk("mode_before_res", addr_mode, 0);
        res_i = 0;
        tick(10);
        res_i = 1;
        tick(4);
        chk("res_addr_mode", addr_mode, 2);
        chk("res_display_on", display_on, 0);
        chk("res_keeps_frame_err", frame_err, 1);
        dat(8'h5A, 0, 0);
        tick(8);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ssd1309_spi_monitor.md
# ssd1309_spi_monitor

Receive-side model of the SSD1309 4-wire SPI link. It oversamples the OLED pins (d0/SCLK, d1/SDIN, D/C, CS, RES) in the 27 MHz system clock domain and assembles MSB-first bytes. It decodes the command stream (addressing mode, column/page windows, page-mode pointers, display on/off) and tags each pixel-data byte with the column/page it lands on. It sits beside the OLED driver on the same pins, for on-board loopback checking and as the responder in driver testbenches.

## Interface

Parameters:
- SYNC_STAGES, 2, synchronizer flops per input pin (≥2)
- COL_MAX, 127, last column index
- PAGE_MAX, 7, last page index

Ports:
- clk  in  1  system clock, 27 MHz
- rst_n  in  1  synchronous, active-low reset
- sclk_i  in  1  SPI clock (OLED d0); asynchronous to clk
- sdin_i  in  1  SPI data (OLED d1); sampled on sclk rising edge
- dc_i  in  1  D/C; 0 = command, 1 = pixel data
- cs_i  in  1  chip select, active low
- res_i  in  1  OLED reset, active low
- byte_valid  out  1  one-cycle pulse per completed byte
- byte_data  out  8  received byte; held until next byte_valid
- byte_dc  out  1  D/C value latched with byte_data
- pix_we  out  1  one-cycle pulse, equals byte_valid & byte_dc
- pix_col  out  7  column the data byte was written to (pre-advance)
- pix_page  out  3  page the data byte was written to (pre-advance)
- addr_mode  out  2  current addressing mode (0 horiz, 1 vert, 2 page)
- display_on  out  1  1 after 0xAF, 0 after 0xAE
- frame_err  out  1  sticky protocol-error flag

## Operation

- All five pins pass through SYNC_STAGES flops. The edge detector compares the last synchronized sclk with the previous one.
- Shift register: when a rising sclk edge is detected with synced cs low, shift in synced sdin (MSB first) and increment bit_cnt[2:0]. The 8th bit completes the byte; dc is sampled with the 8th bit.
- Synced cs going high with bit_cnt≠0: discard the partial byte, clear bit_cnt, set frame_err. Sclk edges while cs is high are ignored.
- Parser states: IDLE, ARG1, ARG2. It consumes command bytes (dc=0).
  - IDLE, 0x20: go to ARG1. The argument's [1:0] loads addr_mode; value 3 loads 2.
  - IDLE, 0x21 (column window): ARG1 = col_start, ARG2 = col_end. Col pointer ← col_start on ARG2.
  - IDLE, 0x22 (page window): ARG1 = page_start, ARG2 = page_end. Page pointer ← page_start on ARG2.
  - IDLE, one-argument commands 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB: go to ARG1 and discard the argument.
  - IDLE, 0x00–0x0F: col[3:0] ← low nibble. 0x10–0x17: col[6:4] ← low bits. 0xB0–0xB7: page ← byte[2:0].
  - IDLE, 0xAE / 0xAF: display_on ← 0 / 1.
  - All other commands: no-op, stay IDLE.
- Argument widths: column arguments use [6:0], page arguments use [2:0]. Upper bits are ignored.
- Data byte (dc=1): pulse pix_we with the current col/page, then advance the pointers:
  - horiz: col==col_end → col←col_start, page advances (page==page_end → page_start); else col+1.
  - vert: page==page_end → page←page_start, col advances (col==col_end → col_start); else page+1.
  - page: col==COL_MAX → 0, else col+1. Page is unchanged.
- Data byte while parser is in ARG1/ARG2: abort the command (parser → IDLE, arguments dropped), set frame_err, and still write/advance the data byte.
- Cs high between command and argument bytes is legal; parser state is retained.
- Defaults (rst_n low, or synced res low): addr_mode=2, col=0, page=0, col window 0..COL_MAX, page window 0..PAGE_MAX, display_on=0, parser IDLE, bit_cnt=0.
- frame_err is cleared only by rst_n, not by res.

## Timing

- Reset values: byte_valid=0, byte_data=0x00, byte_dc=0, pix_we=0, pix_col=0, pix_page=0, addr_mode=2, display_on=0, frame_err=0.
- Input constraint: sclk high and low each ≥ SYNC_STAGES+1 clk cycles. Dc, cs and sdin are stable for the same time around the sclk rising edge.
- Latency: byte_valid/pix_we pulse SYNC_STAGES+1 clk cycles after the first clk edge at which sclk_i is sampled high on the 8th bit.
- Command effects (addr_mode, display_on, pointers) are visible on the cycle after byte_valid.
- pix_col/pix_page are registered with pix_we and held until the next pix_we.
- rst_n low overrides everything. It takes effect at the next clk edge, including mid-byte (no frame_err set).

## Test plan

- Bytes 0xA5 then 0x3C with dc=0, cs low throughout → two byte_valid pulses, byte_data 0xA5 then 0x3C, byte_dc=0, no pix_we.
- Cmds 0x20,0x00, 0x21,0x7E,0x7F, 0x22,0x06,0x07, then 5 data bytes → pix (col,page) = (126,6),(127,6),(126,7),(127,7),(126,6).
- Vertical mode: 0x20,0x01, window col 0..1, page 0..1, then 5 data bytes → (0,0),(0,1),(1,0),(1,1),(0,0).
- Page mode: 0xB3, 0x0F, 0x17, then 2 data bytes → (127,3) then (0,3).
- Cs raised after 5 bits, then full byte 0xAF → partial byte dropped, frame_err=1, display_on=1.
- Cmd 0x21 then data byte 0xFF → frame_err=1, pix_we at the current pointer, parser IDLE. Next, res_i low for 10 cycles → addr_mode=2, pointers 0, frame_err stays 1.
